opcode_sequencer: RTL and testbench

- Parametrised multi-cycle 6502 instruction decoder and sequencer.
- Accepts the opcode byte and 0–2 operand bytes over a valid/ready byte stream from the fetch unit.
- Classifies the addressing mode from the aaa/bbb/cc fields and computes the effective address, including index wrap and branch targets.
- Issues one registered decoded-instruction record per instruction to the execute stage over a second valid/ready handshake.

---
 rtl/opcode_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_opcode_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: multi-cycle 6502 decoder/sequencer; optional illegal-opcode trap via DECODER_ILLEGAL_TRAP_EN
module opcode_sequencer #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int OPP_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_WIDTH-1:0]  in_byte,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [REG_WIDTH-1:0]  x_reg,
    input  logic [REG_WIDTH-1:0]  y_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPP_WIDTH-1:0]  out_opp,
    output logic [REG_WIDTH-1:0]  out_opcode,
    output logic [3:0]            out_mode,
    output logic [ADDR_WIDTH-1:0] out_ea,
    output logic [REG_WIDTH-1:0]  out_imm,
    output logic [1:0]            out_len,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_page_cross,
    output logic                  out_illegal
);
    localparam int HI_W = ADDR_WIDTH - REG_WIDTH;
    localparam logic [3:0] M_IMPL = 4'd0, M_ACC = 4'd1, M_IMM = 4'd2, M_ZP = 4'd3,
                           M_ZPX = 4'd4, M_ZPY = 4'd5, M_ABS = 4'd6, M_ABSX = 4'd7,
                           M_ABSY = 4'd8, M_INDX = 4'd9, M_INDY = 4'd10, M_REL = 4'd11,
                           M_IND = 4'd12;
`ifdef DECODER_ILLEGAL_TRAP_EN
    localparam logic [3:0] M_BAD  = 4'd15;
    localparam logic       TRAP   = 1'b1;
`else
    localparam logic [3:0] M_BAD  = M_IMPL;
    localparam logic       TRAP   = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, OPER_LO, OPER_HI, ISSUE, HALT} state_t;

    state_t                state;
    logic [REG_WIDTH-1:0]  op_q, lo_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [1:0]            len_q;

    logic                  xfer, fin, bad, iy, pcx;
    logic [2:0]            aaa, bbb;
    logic [1:0]            cc;
    logic [3:0]            mode;
    logic [1:0]            dec_len;
    logic [REG_WIDTH-1:0]  cur_op, cur_lo, cur_hi, idx, zp_sum;
    logic [ADDR_WIDTH-1:0] cur_pc, abs_base, abs_sum, rel_base, rel_sum, ea;

    assign xfer   = in_valid && in_ready;
    assign cur_op = (state == IDLE) ? in_byte : op_q;
    assign cur_pc = (state == IDLE) ? in_pc : pc_q;
    assign cur_lo = (state == OPER_LO) ? in_byte : (state == OPER_HI) ? lo_q : '0;
    assign cur_hi = (state == OPER_HI) ? in_byte : '0;
    assign fin    = xfer && ((state == IDLE && dec_len == 2'd1) ||
                             (state == OPER_LO && len_q == 2'd2) || state == OPER_HI);

    // Classify addressing mode and instruction length from the aaa/bbb/cc fields
    always_comb begin
        aaa  = cur_op[7:5];
        bbb  = cur_op[4:2];
        cc   = cur_op[1:0];
        iy   = aaa[2:1] == 2'b10;
        mode = M_IMPL;
        bad  = 1'b0;
        if (cc == 2'b01) begin
            case (bbb)
                3'b000:  mode = M_INDX;
                3'b001:  mode = M_ZP;
                3'b010:  mode = M_IMM;
                3'b011:  mode = M_ABS;
                3'b100:  mode = M_INDY;
                3'b101:  mode = M_ZPX;
                3'b110:  mode = M_ABSY;
                default: mode = M_ABSX;
            endcase
            bad = cur_op == REG_WIDTH'(8'h89);
        end else if (cc == 2'b10) begin
            case (bbb)
                3'b000: begin
                    mode = M_IMM;
                    bad  = aaa < 3'b101;
                end
                3'b001:  mode = M_ZP;
                3'b010:  mode = (aaa < 3'b100) ? M_ACC : M_IMPL;
                3'b011:  mode = M_ABS;
                3'b100:  bad  = 1'b1;
                3'b101:  mode = iy ? M_ZPY : M_ZPX;
                3'b110:  mode = M_IMPL;
                default: mode = iy ? M_ABSY : M_ABSX;
            endcase
        end else if (cc == 2'b00) begin
            if (bbb == 3'b100)
                mode = M_REL;
            else if (bbb == 3'b010 || bbb == 3'b110)
                mode = M_IMPL;
            else if (cur_op == REG_WIDTH'(8'h00) || cur_op == REG_WIDTH'(8'h40) ||
                     cur_op == REG_WIDTH'(8'h60))
                mode = M_IMPL;
            else if (cur_op == REG_WIDTH'(8'h20))
                mode = M_ABS;
            else if (cur_op == REG_WIDTH'(8'h6C))
                mode = M_IND;
            else if (bbb == 3'b000 && aaa >= 3'b101)
                mode = M_IMM;
            else if (bbb[0])
                mode = (bbb[2:1] == 2'b00) ? M_ZP :
                       (bbb[2:1] == 2'b01) ? M_ABS :
                       (bbb[2:1] == 2'b10) ? (iy ? M_ZPY : M_ZPX) :
                                             (iy ? M_ABSY : M_ABSX);
            else
                bad = 1'b1;
        end else begin
            bad = 1'b1;
        end
        mode    = bad ? M_BAD : mode;
        dec_len = (bad || mode == M_IMPL || mode == M_ACC) ? 2'd1 :
                  (mode == M_ABS || mode == M_ABSX || mode == M_ABSY || mode == M_IND) ? 2'd3 :
                  2'd2;
    end

    assign idx      = (mode == M_ZPY || mode == M_ABSY) ? y_reg : x_reg;
    assign zp_sum   = cur_lo + idx;
    assign abs_base = ADDR_WIDTH'({cur_hi, cur_lo});
    assign abs_sum  = abs_base + ADDR_WIDTH'(idx);
    assign rel_base = cur_pc + ADDR_WIDTH'(2);
    assign rel_sum  = rel_base + {{HI_W{cur_lo[REG_WIDTH-1]}}, cur_lo};

    // Effective address and page-cross detection for the instruction being completed
    always_comb begin
        ea  = '0;
        pcx = 1'b0;
        case (mode)
            M_ZP, M_INDY:         ea = ADDR_WIDTH'(cur_lo);
            M_ZPX, M_ZPY, M_INDX: ea = ADDR_WIDTH'(zp_sum);
            M_ABS, M_IND:         ea = abs_base;
            M_ABSX, M_ABSY: begin
                ea  = abs_sum;
                pcx = abs_sum[ADDR_WIDTH-1:REG_WIDTH] != abs_base[ADDR_WIDTH-1:REG_WIDTH];
            end
            M_REL: begin
                ea  = rel_sum;
                pcx = rel_sum[ADDR_WIDTH-1:REG_WIDTH] != rel_base[ADDR_WIDTH-1:REG_WIDTH];
            end
            default: ea = '0;
        endcase
    end

    // Byte-collection FSM; the record is registered on the final byte transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            op_q           <= '0;
            lo_q           <= '0;
            pc_q           <= '0;
            len_q          <= '0;
            out_opp        <= '0;
            out_opcode     <= '0;
            out_mode       <= '0;
            out_ea         <= '0;
            out_imm        <= '0;
            out_len        <= '0;
            out_pc         <= '0;
            out_page_cross <= 1'b0;
            out_illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (xfer) begin
                    op_q  <= in_byte;
                    pc_q  <= in_pc;
                    len_q <= dec_len;
                    state <= OPER_LO;
                end
                OPER_LO: if (xfer) begin
                    lo_q  <= in_byte;
                    state <= OPER_HI;
                end
                OPER_HI: ;
                ISSUE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= (TRAP && out_illegal) ? HALT : IDLE;
                    in_ready  <= !(TRAP && out_illegal);
                end
                HALT: ;
                default: state <= IDLE;
            endcase
            if (fin) begin
                state          <= ISSUE;
                in_ready       <= 1'b0;
                out_valid      <= 1'b1;
                out_opp        <= OPP_WIDTH'({cur_op[7:5], cur_op[1:0]});
                out_opcode     <= cur_op;
                out_mode       <= mode;
                out_ea         <= ea;
                out_imm        <= cur_lo;
                out_len        <= dec_len;
                out_pc         <= cur_pc;
                out_page_cross <= pcx;
                out_illegal    <= TRAP && bad;
            end
        end
    end
endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer: scoreboard bench for opcode_sequencer
module tb_opcode_sequencer;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_byte = '0, x_reg = '0, y_reg = '0;
    logic [15:0] in_pc = '0;
    logic        in_ready, out_valid, out_page_cross, out_illegal;
    logic [4:0]  out_opp;
    logic [7:0]  out_opcode, out_imm;
    logic [3:0]  out_mode;
    logic [15:0] out_ea, out_pc;
    logic [1:0]  out_len;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  mode;
        logic [15:0] ea;
        logic [7:0]  imm;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        pcx;
        logic        ill;
    } rec_t;

    rec_t sb[$];
    rec_t e;
    int   errors = 0, checks = 0, n_rec = 0, n_push = 0;

    opcode_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_pc(in_pc), .x_reg(x_reg), .y_reg(y_reg),
        .out_valid(out_valid), .out_ready(out_ready), .out_opp(out_opp),
        .out_opcode(out_opcode), .out_mode(out_mode), .out_ea(out_ea),
        .out_imm(out_imm), .out_len(out_len), .out_pc(out_pc),
        .out_page_cross(out_page_cross), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [7:0] op, input logic [3:0] mode, input logic [15:0] ea,
                                input logic [7:0] imm, input logic [1:0] len, input logic [15:0] pc,
                                input logic pcx, input logic ill);
        rec_t r;
        r.op = op; r.mode = mode; r.ea = ea; r.imm = imm;
        r.len = len; r.pc = pc; r.pcx = pcx; r.ill = ill;
        return r;
    endfunction

    // Compare each accepted record against the oldest expectation
    always begin
        @(negedge clk);
        #2;
        if (!reset && out_valid && out_ready) begin
            n_rec++;
            check("rec_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("opcode", out_opcode, e.op);
                check("opp", out_opp, {e.op[7:5], e.op[1:0]});
                check("mode", out_mode, e.mode);
                check("ea", out_ea, e.ea);
                check("imm", out_imm, e.imm);
                check("len", out_len, e.len);
                check("pc", out_pc, e.pc);
                check("page_cross", out_page_cross, e.pcx);
                check("illegal", out_illegal, e.ill);
            end
        end
    end

    task automatic put_byte(input logic [7:0] b, input logic [15:0] pc);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_byte = b; in_pc = pc;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic send(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                        input int nb, input logic [15:0] pc, input rec_t r, input bit drain);
        sb.push_back(r);
        n_push++;
        put_byte(op, pc);
        if (nb > 0) put_byte(b1, 16'hDEAD);
        if (nb > 1) put_byte(b2, 16'hBEEF);
        check("latency", out_valid, 1);
        if (drain) wait_drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mode", out_mode, 0);
        check("rst_ea", out_ea, 0);
        check("rst_len", out_len, 0);
        check("rst_illegal", out_illegal, 0);

        send(8'hA9, 8'h42, 8'h00, 1, 16'h1000, mk(8'hA9, 4'd2, 16'h0000, 8'h42, 2'd2, 16'h1000, 0, 0), 1);
        x_reg = 8'hF5;
        send(8'hB5, 8'h10, 8'h00, 1, 16'h1002, mk(8'hB5, 4'd4, 16'h0005, 8'h10, 2'd2, 16'h1002, 0, 0), 1);
        y_reg = 8'h01;
        send(8'hB9, 8'hFF, 8'h12, 2, 16'h1004, mk(8'hB9, 4'd8, 16'h1300, 8'hFF, 2'd3, 16'h1004, 1, 0), 1);
        x_reg = 8'h05;
        send(8'hBD, 8'h00, 8'h20, 2, 16'h1007, mk(8'hBD, 4'd7, 16'h2005, 8'h00, 2'd3, 16'h1007, 0, 0), 1);
        send(8'h90, 8'h20, 8'h00, 1, 16'h02F0, mk(8'h90, 4'd11, 16'h0312, 8'h20, 2'd2, 16'h02F0, 1, 0), 1);
        send(8'h6C, 8'h00, 8'h30, 2, 16'h2000, mk(8'h6C, 4'd12, 16'h3000, 8'h00, 2'd3, 16'h2000, 0, 0), 1);
        x_reg = 8'h20;
        send(8'hA1, 8'hF0, 8'h00, 1, 16'h3000, mk(8'hA1, 4'd9, 16'h0010, 8'hF0, 2'd2, 16'h3000, 0, 0), 1);
        y_reg = 8'hFF;
        send(8'hB1, 8'h80, 8'h00, 1, 16'h3002, mk(8'hB1, 4'd10, 16'h0080, 8'h80, 2'd2, 16'h3002, 0, 0), 1);
        send(8'hEA, 8'h00, 8'h00, 0, 16'h4000, mk(8'hEA, 4'd0, 16'h0000, 8'h00, 2'd1, 16'h4000, 0, 0), 1);
        send(8'h0A, 8'h00, 8'h00, 0, 16'h4001, mk(8'h0A, 4'd1, 16'h0000, 8'h00, 2'd1, 16'h4001, 0, 0), 1);
        send(8'h85, 8'h10, 8'h00, 1, 16'h4002, mk(8'h85, 4'd3, 16'h0010, 8'h10, 2'd2, 16'h4002, 0, 0), 1);

        out_ready = 1'b0;
        send(8'hD0, 8'hFE, 8'h00, 1, 16'h0200, mk(8'hD0, 4'd11, 16'h0200, 8'hFE, 2'd2, 16'h0200, 0, 0), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_ea", out_ea, 16'h0200);
            check("stall_mode", out_mode, 4'd11);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_accept_valid", out_valid, 0);
        check("post_accept_in_ready", in_ready, 1);
        wait_drain();

        put_byte(8'hAD, 16'h5000);
        put_byte(8'h34, 16'h0000);
        do_reset();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_valid", out_valid, 0);
        send(8'hA9, 8'h42, 8'h00, 1, 16'h5100, mk(8'hA9, 4'd2, 16'h0000, 8'h42, 2'd2, 16'h5100, 0, 0), 1);

`ifdef DECODER_ILLEGAL_TRAP_EN
        send(8'h02, 8'h00, 8'h00, 0, 16'h6000, mk(8'h02, 4'd15, 16'h0000, 8'h00, 2'd1, 16'h6000, 0, 1), 1);
        @(negedge clk);
        in_valid = 1'b1; in_byte = 8'hEA;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("halt_in_ready", in_ready, 0);
            check("halt_valid", out_valid, 0);
        end
        do_reset();
        check("halt_reset_in_ready", in_ready, 1);
`else
        send(8'h02, 8'h00, 8'h00, 0, 16'h6000, mk(8'h02, 4'd0, 16'h0000, 8'h00, 2'd1, 16'h6000, 0, 0), 1);
        send(8'hEA, 8'h00, 8'h00, 0, 16'h6001, mk(8'hEA, 4'd0, 16'h0000, 8'h00, 2'd1, 16'h6001, 0, 0), 1);
`endif
        repeat (3) @(negedge clk);
        check("rec_count", n_rec, n_push);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
